// File: rtl/ioctl_pkg.sv
// ioctl_pkg: shared address width, writer FSM encoding and FIFO entry layout.
package ioctl_pkg;
   localparam int IOCTL_ADDR_W = 25;
   localparam int IOCTL_DATA_W = 8;
   typedef enum logic {IDLE, WAIT} wr_state_t;
   typedef struct packed {
      logic [IOCTL_ADDR_W-1:0] addr;
      logic [IOCTL_DATA_W-1:0] data;
   } ioctl_entry_t;
endpackage

// File: rtl/ioctl_mem_writer_if.sv
// ioctl_mem_writer_if: req/ack write bus between the ioctl writer and the memory arbiter.
interface ioctl_mem_writer_if import ioctl_pkg::*; #(parameter int ADDR_W = IOCTL_ADDR_W);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic              mem_ack;
   modport master (output mem_req, mem_addr, mem_din, input mem_ack);
   modport slave  (input mem_req, mem_addr, mem_din, output mem_ack);
endinterface

// File: rtl/ioctl_wfifo.sv
// ioctl_wfifo: synchronous FIFO of 2**AW entries of W bits with full/empty/count.
module ioctl_wfifo #(
   parameter int W  = 33,
   parameter int AW = 2
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wp, rp;
   logic          do_push, do_pop;
   assign full    = count == (AW+1)'(2**AW);
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rp];
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + AW'(do_push);
         rp    <= rp + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk_sys)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ioctl_mem_writer.sv
// ioctl_mem_writer: buffers mist_io ioctl byte writes and replays them over a req/ack bus.
// Define IOCTL_CHECKSUM_EN to add the 16-bit download checksum output.
module ioctl_mem_writer import ioctl_pkg::*; #(
   parameter int FIFO_AW = 2,
   parameter int ADDR_W  = IOCTL_ADDR_W
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_erasing,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   ioctl_mem_writer_if.master mem,
   output logic              busy,
   output logic              done,
   output logic              overflow
`ifdef IOCTL_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);
   logic               full, empty, push, drop, pop, dl_q, er_q, dl_rise, er_rise, busy_q;
   logic [FIFO_AW:0]   count;
   logic [ADDR_W+7:0]  head;
   wr_state_t          state;
   // full comes from the registered count, so a same-cycle pop never rescues a push
   assign push    = ioctl_wr & ~full;
   assign drop    = ioctl_wr & full;
   assign pop     = (state == WAIT) & mem.mem_ack;
   assign dl_rise = ioctl_download & ~dl_q;
   assign er_rise = ioctl_erasing & ~er_q;
   assign busy    = ioctl_download | ioctl_erasing | (count != '0) | mem.mem_req;
   ioctl_wfifo #(.W(ADDR_W + 8), .AW(FIFO_AW)) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .din     ({ioctl_addr, ioctl_dout}),
      .dout    (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         state        <= IDLE;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= '0;
         mem.mem_din  <= '0;
      end else if (state == IDLE) begin
         if (!empty) begin
            mem.mem_addr <= head[ADDR_W+7:8];
            mem.mem_din  <= head[7:0];
            mem.mem_req  <= 1'b1;
            state        <= WAIT;
         end
      end else if (mem.mem_ack) begin
         mem.mem_req <= 1'b0;
         state       <= IDLE;
      end
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         busy_q   <= 1'b0;
         done     <= 1'b0;
         dl_q     <= 1'b0;
         er_q     <= 1'b0;
         overflow <= 1'b0;
`ifdef IOCTL_CHECKSUM_EN
         checksum <= '0;
`endif
      end else begin
         busy_q   <= busy;
         done     <= busy_q & ~busy;
         dl_q     <= ioctl_download;
         er_q     <= ioctl_erasing;
         overflow <= drop | (overflow & ~(dl_rise | er_rise));
`ifdef IOCTL_CHECKSUM_EN
         checksum <= (dl_rise ? 16'h0 : checksum) + ((push & ioctl_download) ? {8'h0, ioctl_dout} : 16'h0);
`endif
      end
endmodule

// File: tb/tb_ioctl_mem_writer.sv
// tb_ioctl_mem_writer: scoreboard bench with a delayed-ack arbiter model.
module tb_ioctl_mem_writer;
   import ioctl_pkg::*;
   logic clk_sys = 0, reset = 0, ioctl_download = 0, ioctl_erasing = 0, ioctl_wr = 0;
   logic [IOCTL_ADDR_W-1:0] ioctl_addr = '0;
   logic [7:0] ioctl_dout = '0;
   logic busy, done, overflow;
`ifdef IOCTL_CHECKSUM_EN
   logic [15:0] checksum;
`endif
   int checks = 0, errors = 0, n_out = 0, done_cnt = 0, ack_delay = 3, wait_cnt = 0;
   logic [32:0] exp_q[$];
   logic [32:0] held = '0;
   logic req_q = 0;
   ioctl_mem_writer_if bus();
   ioctl_mem_writer dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_erasing  (ioctl_erasing),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .mem            (bus),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow)
`ifdef IOCTL_CHECKSUM_EN
      ,
      .checksum       (checksum)
`endif
   );
   always #5 clk_sys = ~clk_sys;
   // arbiter: ack pulses ack_delay cycles after it first sees mem_req
   initial begin
      bus.mem_ack = 0;
      forever begin
         @(posedge clk_sys);
         #1;
         if (reset || bus.mem_ack) begin
            bus.mem_ack = 0;
            wait_cnt = 0;
         end else if (bus.mem_req) begin
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
               bus.mem_ack = 1;
               wait_cnt = 0;
            end
         end else wait_cnt = 0;
      end
   end
   // scoreboard: each new request must match the oldest accepted write and stay stable
   initial begin
      forever begin
         @(negedge clk_sys);
         if (bus.mem_req && !req_q) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL req_order: got unexpected request %h/%h, required none", bus.mem_addr, bus.mem_din);
               held = {bus.mem_addr, bus.mem_din};
            end else begin
               held = exp_q.pop_front();
               if ({bus.mem_addr, bus.mem_din} !== held) begin
                  errors++;
                  $display("FAIL req_order: got %h, required %h", {bus.mem_addr, bus.mem_din}, held);
               end
            end
            n_out++;
         end else if (bus.mem_req) begin
            checks++;
            if ({bus.mem_addr, bus.mem_din} !== held) begin
               errors++;
               $display("FAIL req_stable: got %h, required %h", {bus.mem_addr, bus.mem_din}, held);
            end
         end
         if (done) done_cnt++;
         req_q = bus.mem_req;
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask
   task automatic pulse(input logic [24:0] a, input logic [7:0] d, input bit acc);
      ioctl_wr = 1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (acc) exp_q.push_back({a, d});
      @(posedge clk_sys);
      #1;
      ioctl_wr = 0;
   endtask
   task automatic wait_idle(input int lim, input string tag);
      int k = 0;
      while (busy && k < lim) begin
         cyc(1);
         k++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s_idle: busy still 1 after %0d cycles, required 0", tag, lim);
      end
   endtask
   task automatic test_reset;
      #2 reset = 1;
      cyc(2);
      checks++;
      if ({bus.mem_req, busy, done, overflow} !== 4'b0 || bus.mem_addr !== '0 || bus.mem_din !== '0) begin
         errors++;
         $display("FAIL reset: req/busy/done/ovf=%b addr=%h din=%h, required all 0", {bus.mem_req, busy, done, overflow}, bus.mem_addr, bus.mem_din);
      end
`ifdef IOCTL_CHECKSUM_EN
      checks++;
      if (checksum !== 16'h0) begin
         errors++;
         $display("FAIL reset_checksum: got %h, required 0000", checksum);
      end
`endif
      reset = 0;
      cyc(2);
      checks++;
      if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: req=%b busy=%b, required 0 0", bus.mem_req, busy);
      end
   endtask
   task automatic test_single;
      int dc = done_cnt;
      ack_delay = 3;
      pulse(25'h170000, 8'hA5, 1);
      checks++;
      if (bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL single_early: mem_req=%b one cycle after wr, required 0", bus.mem_req);
      end
      cyc(1);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 25'h170000 || bus.mem_din !== 8'hA5) begin
         errors++;
         $display("FAIL single_req: req=%b addr=%h din=%h, required 1 0170000 a5", bus.mem_req, bus.mem_addr, bus.mem_din);
      end
      cyc(3);
      checks++;
      if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_drop: req=%b busy=%b after ack, required 0 0", bus.mem_req, busy);
      end
      cyc(1);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL single_done: done=%b, required 1", done);
      end
      cyc(2);
      checks++;
      if (done_cnt - dc != 1) begin
         errors++;
         $display("FAIL single_done_count: %0d pulses, required 1", done_cnt - dc);
      end
   endtask
   task automatic test_burst;
      int o = n_out;
      ack_delay = 20;
      for (int i = 0; i < 4; i++) pulse(25'h100 + 25'(i), 8'h11 * 8'(i + 1), 1);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL burst_no_ovf: overflow=%b, required 0", overflow);
      end
      pulse(25'h104, 8'h55, 0);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL burst_ovf: overflow=%b, required 1", overflow);
      end
      wait_idle(300, "burst");
      checks++;
      if (n_out - o != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL burst_count: %0d emerged with %0d pending, required 4 and 0", n_out - o, exp_q.size());
      end
   endtask
   task automatic test_overflow_clear;
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pre: overflow=%b, required 1", overflow);
      end
      ioctl_download = 1;
      cyc(1);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
      end
      ioctl_download = 0;
      cyc(1);
      wait_idle(20, "ovf_clear");
   endtask
   task automatic test_simultaneous;
      int o = n_out;
      int k = 0;
      ack_delay = 6;
      for (int i = 0; i < 4; i++) pulse(25'h1F0000 + 25'(i), 8'hC0 + 8'(i), 1);
      while (!bus.mem_ack && k < 50) begin
         @(negedge clk_sys);
         k++;
      end
      checks++;
      if (!bus.mem_ack) begin
         errors++;
         $display("FAIL simul_ack: no ack within 50 cycles, required one");
      end
      pulse(25'h1F0004, 8'hEE, 0);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL simul_ovf: overflow=%b, required 1", overflow);
      end
      wait_idle(200, "simul");
      checks++;
      if (n_out - o != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL simul_count: %0d emerged with %0d pending, required 4 and 0", n_out - o, exp_q.size());
      end
   endtask
   task automatic test_reset_mid;
      int o = n_out;
      int k = 0;
      ack_delay = 50;
      pulse(25'h1ABCDE, 8'h5A, 1);
      while (!bus.mem_req && k < 10) begin
         cyc(1);
         k++;
      end
      @(negedge clk_sys);
      reset = 1;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.mem_addr !== '0) begin
         errors++;
         $display("FAIL reset_mid: req=%b busy=%b addr=%h, required 0 0 0", bus.mem_req, busy, bus.mem_addr);
      end
      cyc(2);
      @(negedge clk_sys);
      reset = 0;
      cyc(10);
      checks++;
      if (bus.mem_req !== 1'b0 || n_out - o != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: req=%b requests=%0d pending=%0d, required 0 1 0", bus.mem_req, n_out - o, exp_q.size());
      end
      ack_delay = 2;
      pulse(25'h000123, 8'h3C, 1);
      wait_idle(50, "reset_mid");
      checks++;
      if (n_out - o != 2) begin
         errors++;
         $display("FAIL reset_mid_resume: %0d requests, required 2", n_out - o);
      end
   endtask
`ifdef IOCTL_CHECKSUM_EN
   task automatic test_checksum;
      logic [7:0] bytes [3] = '{8'hFF, 8'hFF, 8'h03};
      ack_delay = 2;
      ioctl_download = 1;
      cyc(1);
      for (int i = 0; i < 3; i++) begin
         pulse(25'(i), bytes[i], 1);
         cyc(6);
      end
      checks++;
      if (checksum !== 16'h0201) begin
         errors++;
         $display("FAIL checksum_dl: got %h, required 0201", checksum);
      end
      ioctl_download = 0;
      ioctl_erasing = 1;
      for (int i = 0; i < 16; i++) begin
         pulse(25'h8000 + 25'(i), 8'hFF, 1);
         cyc(6);
      end
      ioctl_erasing = 0;
      cyc(1);
      wait_idle(50, "checksum");
      checks++;
      if (checksum !== 16'h0201 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL checksum_erase: got %h pending %0d, required 0201 and 0", checksum, exp_q.size());
      end
   endtask
`endif
   initial begin
      test_reset;
      test_single;
      test_burst;
      test_overflow_clear;
      test_simultaneous;
      test_reset_mid;
`ifdef IOCTL_CHECKSUM_EN
      test_checksum;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
